ccff_chain_loader: RTL

CCFF_CHAIN_LOADER -- requirements
Module: ccff_chain_loader

---
 rtl/ccff_chain_loader_if.sv | 15 +
 rtl/ccff_chain_loader.sv | 133 +++++++++++++
 2 files changed

// File: rtl/ccff_chain_loader_if.sv
// Word stream from the configuration source into the chain loader.
//   s_valid : source has a configuration word available
//   s_data  : configuration word, bit 0 is the first bit shifted out
//   s_ready : loader takes the word this cycle
// master = word source, slave = ccff_chain_loader.
interface ccff_chain_loader_if #(
    parameter int WORD_W = 8
);
    logic              s_valid;
    logic [WORD_W-1:0] s_data;
    logic              s_ready;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/ccff_chain_loader.sv
// Serial loader for a CHAIN_LEN-long configuration flop chain.
// Takes WORD_W-bit words from the word stream and shifts them into the
// chain head LSB first, one bit per prog_clk cycle with chain_en high.
// The bits returning on ccff_tail are folded into tail_parity, which ends
// up as the parity of the chain contents that were overwritten.
// Ports:
//   prog_clk, pReset_n : clock, synchronous active-low reset
//   start, abort       : begin a full load / cancel the load in progress
//   s_if               : word stream (slave side)
//   ccff_head, chain_en: registered serial data and shift enable to the chain
//   ccff_tail          : serial data returning from the chain tail
//   busy, done         : load in progress / one-cycle completion pulse
//   aborted            : sticky, last load was cancelled
//   tail_parity        : XOR of tail bits seen in the current/last load
//   bit_count          : bits shifted in the current/last load
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | no load in progress, waiting for start
// WAIT_WORD | load in progress, s_ready high, waiting for the next word
// SHIFT     | shifting the current word into the chain, one bit/cycle
// DONE      | all CHAIN_LEN bits shifted, done pulses, back to IDLE
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 12,
    parameter int WORD_W    = 8
) (
    input  logic                             prog_clk,
    input  logic                             pReset_n,
    input  logic                             start,
    input  logic                             abort,
    ccff_chain_loader_if.slave               s_if,
    output logic                             ccff_head,
    output logic                             chain_en,
    input  logic                             ccff_tail,
    output logic                             busy,
    output logic                             done,
    output logic                             aborted,
    output logic                             tail_parity,
    output logic [$clog2(CHAIN_LEN+1)-1:0]   bit_count
);
    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int WB_W  = $clog2(WORD_W + 1);

    typedef enum logic [1:0] {IDLE, WAIT_WORD, SHIFT, DONE} state_t;

    state_t            state;
    logic [WORD_W-1:0] shreg;
    logic [WB_W-1:0]   wbit;
    logic              last_bit;

    // A word ends either at its own MSB or when the chain is full, so the
    // unused upper bits of a short final word are never shifted.
    assign last_bit = (wbit == WB_W'(WORD_W - 1)) ||
                      (bit_count == CNT_W'(CHAIN_LEN - 1));

    // Abort blocks the handshake so a word offered alongside it stays put.
    assign s_if.s_ready = (state == WAIT_WORD) && !abort;

    always_ff @(posedge prog_clk) begin
        if (!pReset_n) begin
            state       <= IDLE;
            shreg       <= '0;
            wbit        <= '0;
            ccff_head   <= 1'b0;
            chain_en    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            aborted     <= 1'b0;
            tail_parity <= 1'b0;
            bit_count   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= WAIT_WORD;
                        busy        <= 1'b1;
                        bit_count   <= '0;
                        tail_parity <= 1'b0;
                        aborted     <= 1'b0;
                    end
                end
                WAIT_WORD: begin
                    if (abort) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        aborted <= 1'b1;
                    end else if (s_if.s_valid) begin
                        state     <= SHIFT;
                        chain_en  <= 1'b1;
                        ccff_head <= s_if.s_data[0];
                        shreg     <= s_if.s_data >> 1;
                        wbit      <= '0;
                    end
                end
                SHIFT: begin
                    // chain_en was high this cycle, so the chain took the
                    // bit even if abort arrives now: count it.
                    bit_count   <= bit_count + CNT_W'(1);
                    tail_parity <= tail_parity ^ ccff_tail;
                    if (abort) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        chain_en  <= 1'b0;
                        ccff_head <= 1'b0;
                        aborted   <= 1'b1;
                    end else if (last_bit) begin
                        chain_en  <= 1'b0;
                        ccff_head <= 1'b0;
                        if (bit_count == CNT_W'(CHAIN_LEN - 1)) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= WAIT_WORD;
                        end
                    end else begin
                        ccff_head <= shreg[0];
                        shreg     <= shreg >> 1;
                        wbit      <= wbit + WB_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule
